// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: one registered stage per shift bit, valid/ready per stage.
// Optional flush port enabled by SHIFTER_FLUSH_EN.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    localparam int SH_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic [1:0]       in_op,
`ifdef SHIFTER_FLUSH_EN
    input  logic             flush,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             clr;
    logic [SH_W-1:0]  vld;
    logic [SH_W:0]    rdy;
    logic [WIDTH-1:0] dat [SH_W];
    logic [1:0]       opr [SH_W];
    logic [SH_W-1:0]  sha [SH_W];
`ifdef SHIFTER_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif
    assign rdy[SH_W] = out_ready;
    assign in_ready  = rdy[0] && !rst && !clr;
    assign out_valid = vld[SH_W-1];
    assign out_data  = dat[SH_W-1];
    for (genvar k = 0; k < SH_W; k++) begin : g_stage
        localparam int S = 1 << k;
        logic             sv, v_q;
        logic [WIDTH-1:0] sd, sh, d_q;
        logic [1:0]       so, o_q;
        logic [SH_W-1:0]  ss, s_q;
        if (k == 0) begin : g_head
            assign sv = in_valid && in_ready;
            assign sd = in_data;
            assign so = in_op;
            assign ss = in_shamt;
        end else begin : g_body
            assign sv = vld[k-1];
            assign sd = dat[k-1];
            assign so = opr[k-1];
            assign ss = sha[k-1];
        end
        // SRA fill is the sign bit of this stage's input, not of the original operand
        always_comb
            sh = !ss[k]       ? sd :
                 so == 2'd0   ? sd << S :
                 so == 2'd1   ? {{S{1'b0}}, sd[WIDTH-1:S]} :
                 so == 2'd2   ? {{S{sd[WIDTH-1]}}, sd[WIDTH-1:S]} :
                                {sd[S-1:0], sd[WIDTH-1:S]};
        always_ff @(posedge clk)
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
                o_q <= '0;
                s_q <= '0;
            end else if (clr) begin
                v_q <= 1'b0;
            end else if (rdy[k]) begin
                v_q <= sv;
                d_q <= sh;
                o_q <= so;
                s_q <= ss;
            end
        assign rdy[k] = !v_q || rdy[k+1];
        assign vld[k] = v_q;
        assign dat[k] = d_q;
        assign opr[k] = o_q;
        assign sha[k] = s_q;
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed checks of the 32-bit pipelined barrel shifter.
module tb_pipelined_barrel_shifter;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
`ifdef SHIFTER_FLUSH_EN
    logic        flush = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    pipelined_barrel_shifter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
`ifdef SHIFTER_FLUSH_EN
        .flush(flush),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return sd >>> s;
            default: return (d >> s) | (d << (32 - int'(s)));
        endcase
    endfunction

    task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] s,
                           input logic [1:0] o, input logic [31:0] e);
        int lat;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_op = o; out_ready = 1'b1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check(tag, out_data, e);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] held, ed;
        logic [4:0]  es;
        logic [1:0]  eo;
        int got, first, last, acc, seen;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_out_data", out_data, 32'h0);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        run_one("sll4", 32'h8000_00F0, 5'd4, 2'd0, 32'h0000_0F00);
        run_one("srl4", 32'h8000_00F0, 5'd4, 2'd1, 32'h0800_000F);
        run_one("sra4", 32'h8000_00F0, 5'd4, 2'd2, 32'hF800_000F);
        run_one("ror4", 32'h8000_00F0, 5'd4, 2'd3, 32'h0800_000F);

        got = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            if (c < 16) begin
                in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
                in_op = 2'($urandom_range(0, 3));
                q.push_back(ref_shift(in_data, in_shamt, in_op));
            end else in_valid = 1'b0;
            step();
            if (out_valid) begin
                if (q.size() == 0) check("stream_extra", out_data, 32'hxxxx_xxxx);
                else check("stream", out_data, q.pop_front());
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        check("stream_count", 32'(got), 32'd16);
        check("stream_gap", 32'(last - first), 32'd15);

        out_ready = 1'b0; acc = 0; q = {};
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data = 32'h1234_5678 + 32'(acc * 32'h0101_0101);
            in_shamt = 5'(acc * 3 + 1); in_op = 2'(acc);
            if (in_ready) begin
                q.push_back(ref_shift(in_data, in_shamt, in_op));
                acc++;
            end
            step();
            if (c == 5) held = out_data;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd5);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_stable", out_data, held);
        out_ready = 1'b1; got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (out_valid) begin
                check("bp_drain", out_data, q.size() ? q.pop_front() : 32'hxxxx_xxxx);
                got++;
            end
            step();
        end
        check("bp_drain_count", 32'(got), 32'd5);

        for (int o = 0; o < 4; o++) run_one("shamt0", 32'hDEAD_BEEF, 5'd0, 2'(o), 32'hDEAD_BEEF);
        run_one("sra31", 32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF);
        run_one("ror31", 32'h0000_0001, 5'd31, 2'd3, 32'h0000_0002);

        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = 32'hA5A5_0000 + 32'(c); in_shamt = 5'd1; in_op = 2'd0;
            step();
        end
        in_valid = 1'b0;
`ifdef SHIFTER_FLUSH_EN
        flush = 1'b1;
        step();
        flush = 1'b0;
`else
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        #1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen++;
            step();
        end
        check("clear_no_out", 32'(seen), 32'd0);
        ed = 32'h0000_00FF; es = 5'd8; eo = 2'd0;
        run_one("after_clear", ed, es, eo, 32'h0000_FF00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
